// File: rtl/spi_slave_stream.sv
// spi_slave_stream: SPI slave with runtime mode select, oversampled pins and
// streaming TX/RX word interfaces in the clk_s domain.
// Optional feature macro: SPI_SLAVE_LSB_FIRST_EN (defined = LSB-first in both
// directions, undefined = MSB-first).
module spi_slave_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_s,
  input  logic                  rst_n,
  input  logic                  sclk_s,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;

  state_t                 state_q, state_d;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0]  tx_buf_q, tx_buf_d;
  logic                   tx_full_q, tx_full_d;
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;

  logic                   sclk_in, ss_in, mosi_in;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   do_load, do_shift, do_sample;
  logic                   tx_out_bit;
  logic [DATA_WIDTH-1:0]  tx_shifted, rx_next;

  // Synchronised pin values and edges seen against one extra registered copy
  assign sclk_in   = sclk_sync_q[SYNC_STAGES-1];
  assign ss_in     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_in   = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_in & ~sclk_prev_q;
  assign sclk_fall = ~sclk_in & sclk_prev_q;
  assign ss_fall   = ~ss_in & ss_prev_q;
  assign ss_rise   = ss_in & ~ss_prev_q;

  // Mode decoding uses the copy of cpol/cpha taken at frame start
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign tx_out_bit = tx_shift_q[0];
  assign tx_shifted = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
  assign rx_next    = {mosi_in, rx_shift_q[DATA_WIDTH-1:1]};
`else
  assign tx_out_bit = tx_shift_q[DATA_WIDTH-1];
  assign tx_shifted = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
  assign rx_next    = {rx_shift_q[DATA_WIDTH-2:0], mosi_in};
`endif

  // Next value of the pin synchronisers and edge-detect copies
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_s};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_in;
    ss_prev_d   = ss_in;
  end

  // Frame FSM, shift registers, TX holding buffer and RX handshake
  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    overrun_d  = 1'b0;
    underrun_d = 1'b0;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_sample  = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          cpol_d    = cpol;
          cpha_d    = cpha;
          bit_cnt_d = '0;
          do_load   = ~cpha;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
        end else begin
          do_shift  = shift_edge;
          do_sample = sample_edge;
        end
      end
      default: state_d = IDLE;
    endcase

    // A shift edge at bit 0 starts a new word for both cpha settings
    if (do_shift) begin
      if (bit_cnt_q == '0) begin
        do_load = 1'b1;
      end else begin
        tx_shift_d = tx_shifted;
      end
    end

    if (do_load) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    if (do_sample) begin
      rx_shift_d = rx_next;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d  = '0;
        rx_data_d  = rx_next;
        rx_valid_d = 1'b1;
        overrun_d  = rx_valid_q & ~rx_ready;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    // Accept is gated by the pre-cycle empty flag, so a same-cycle load never sees it
    if (tx_valid && !tx_full_q) begin
      tx_full_d = 1'b1;
      tx_buf_d  = tx_data;
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso     = (state_q == ACTIVE) ? tx_out_bit : 1'b0;
  assign busy     = (state_q == ACTIVE);
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule
